// File: rtl/morse_sequencer.sv
// Morse LED sequencer for letters A..H with a half-second unit prescaler.
// Optional inter-letter gap (TAIL state) enabled by MORSE_LETTER_GAP_EN.
module morse_sequencer #(
  parameter int TICK_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] letter_sel,
  output logic       led,
  output logic       busy,
  output logic       done
);

  localparam logic [24:0] RELOAD = 25'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
`ifdef MORSE_LETTER_GAP_EN
    S_TAIL,
`endif
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pat_q, pat_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [24:0] pre_q, pre_d;
  logic [1:0]  unit_q, unit_d;
  logic        led_q, led_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  lut_pat;
  logic [2:0]  lut_len;
  logic        tick;
  logic        last_unit;

  // Patterns are left-aligned: the current symbol is always pat_q[3].
  always_comb begin
    lut_pat = 4'b0000;
    lut_len = 3'd1;
    unique case (letter_sel)
      3'd0: begin lut_pat = 4'b0100; lut_len = 3'd2; end
      3'd1: begin lut_pat = 4'b1000; lut_len = 3'd4; end
      3'd2: begin lut_pat = 4'b1010; lut_len = 3'd4; end
      3'd3: begin lut_pat = 4'b1000; lut_len = 3'd3; end
      3'd4: begin lut_pat = 4'b0000; lut_len = 3'd1; end
      3'd5: begin lut_pat = 4'b0010; lut_len = 3'd4; end
      3'd6: begin lut_pat = 4'b1100; lut_len = 3'd3; end
      3'd7: begin lut_pat = 4'b0000; lut_len = 3'd4; end
      default: begin lut_pat = 4'b0000; lut_len = 3'd1; end
    endcase
  end

  assign tick      = busy_q && (pre_q == 25'd0);
  assign last_unit = (unit_q == 2'd2);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    unit_d  = unit_q;
    pre_d   = pre_q;
    if (busy_q) begin
      pre_d = tick ? RELOAD : pre_q - 25'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MARK;
          pat_d   = lut_pat;
          cnt_d   = lut_len;
          unit_d  = 2'd0;
          pre_d   = RELOAD;
        end
      end
      S_MARK: begin
        if (tick) begin
          if (!pat_q[3] || last_unit) begin
            unit_d = 2'd0;
            if (cnt_q > 3'd1) begin
              state_d = S_SPACE;
            end else begin
`ifdef MORSE_LETTER_GAP_EN
              state_d = S_TAIL;
`else
              state_d = S_FIN;
`endif
            end
          end else begin
            unit_d = unit_q + 2'd1;
          end
        end
      end
      S_SPACE: begin
        if (tick) begin
          pat_d   = {pat_q[2:0], 1'b0};
          cnt_d   = cnt_q - 3'd1;
          state_d = S_MARK;
        end
      end
`ifdef MORSE_LETTER_GAP_EN
      S_TAIL: begin
        if (tick) begin
          if (last_unit) begin
            unit_d  = 2'd0;
            state_d = S_FIN;
          end else begin
            unit_d = unit_q + 2'd1;
          end
        end
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    led_d  = (state_d == S_MARK);
    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pat_q   <= 4'b0000;
      cnt_q   <= 3'd0;
      unit_q  <= 2'd0;
      pre_q   <= RELOAD;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      pre_q   <= pre_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with TICK_CYCLES=4.
// Per-cycle traces are packed into vectors, bit k = cycle k+1 after accept.
module tb_morse_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [2:0] letter_sel;
  logic       led;
  logic       busy;
  logic       done;

  int total;
  int bad;

  morse_sequencer #(.TICK_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .letter_sel(letter_sel),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic capture(
    input  logic [2:0]  sel,
    input  logic [2:0]  sel_late,
    input  bit          hold,
    input  int          n,
    output logic [63:0] l,
    output logic [63:0] b,
    output logic [63:0] d
  );
    l = '0;
    b = '0;
    d = '0;
    @(negedge clk);
    start      = 1'b1;
    letter_sel = sel;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      l[k] = led;
      b[k] = busy;
      d[k] = done;
      if (k == 0) begin
        letter_sel = sel_late;
        if (!hold) start = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) begin
      total++;
      bad++;
      $display("FAIL %s idle-timeout busy=%b done=%b want 0/0", name, busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    start      = 1'b0;
    letter_sel = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({led, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_hold got=%b want=000", {led, busy, done});
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({led, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_release got=%b want=000", {led, busy, done});
    end
  endtask

  task automatic test_letter_e;
    logic [63:0] l, b, d;
    logic [63:0] el, eb, ed;
`ifdef MORSE_LETTER_GAP_EN
    capture(3'd4, 3'd4, 1'b0, 20, l, b, d);
    el = 64'h0000F;
    eb = 64'h0FFFF;
    ed = 64'h10000;
`else
    capture(3'd4, 3'd4, 1'b0, 8, l, b, d);
    el = 64'h0F;
    eb = 64'h0F;
    ed = 64'h10;
`endif
    total++;
    if (l !== el) begin
      bad++;
      $display("FAIL e_led got=%h want=%h", l, el);
    end
    total++;
    if (b !== eb) begin
      bad++;
      $display("FAIL e_busy got=%h want=%h", b, eb);
    end
    total++;
    if (d !== ed) begin
      bad++;
      $display("FAIL e_done got=%h want=%h", d, ed);
    end
    wait_idle("e");
  endtask

  task automatic test_letter_a;
    logic [63:0] l, b, d;
    capture(3'd0, 3'd0, 1'b0, 24, l, b, d);
    total++;
    if (l !== 64'h0FFF0F) begin
      bad++;
      $display("FAIL a_led got=%h want=%h", l, 64'h0FFF0F);
    end
    total++;
    if (b !== 64'h0FFFFF) begin
      bad++;
      $display("FAIL a_busy got=%h want=%h", b, 64'h0FFFFF);
    end
    total++;
    if (d !== 64'h100000) begin
      bad++;
      $display("FAIL a_done got=%h want=%h", d, 64'h100000);
    end
    wait_idle("a");
  endtask

  task automatic test_back_to_back;
    logic [63:0] l, b, d;
    capture(3'd7, 3'd7, 1'b1, 32, l, b, d);
    total++;
    if (l !== 64'hCF0F0F0F) begin
      bad++;
      $display("FAIL h_led got=%h want=%h", l, 64'hCF0F0F0F);
    end
    total++;
    if (b !== 64'hCFFFFFFF) begin
      bad++;
      $display("FAIL h_busy got=%h want=%h", b, 64'hCFFFFFFF);
    end
    total++;
    if (d !== 64'h10000000) begin
      bad++;
      $display("FAIL h_done got=%h want=%h", d, 64'h10000000);
    end
    start = 1'b0;
    wait_idle("h");
  endtask

  task automatic test_sel_change;
    logic [63:0] l, b, d;
    capture(3'd3, 3'd7, 1'b0, 32, l, b, d);
    total++;
    if (l !== 64'h0F0F0FFF) begin
      bad++;
      $display("FAIL d_led got=%h want=%h", l, 64'h0F0F0FFF);
    end
    total++;
    if (b !== 64'h0FFFFFFF) begin
      bad++;
      $display("FAIL d_busy got=%h want=%h", b, 64'h0FFFFFFF);
    end
    total++;
    if (d !== 64'h10000000) begin
      bad++;
      $display("FAIL d_done got=%h want=%h", d, 64'h10000000);
    end
    wait_idle("d");
  endtask

  task automatic test_mid_reset;
    logic [63:0] l, b, d;
    capture(3'd1, 3'd1, 1'b0, 6, l, b, d);
    total++;
    if (l[5:0] !== 6'h3F) begin
      bad++;
      $display("FAIL rst_pre_led got=%h want=3f", l[5:0]);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({led, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_async got=%b want=000", {led, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if ({led, busy, done} !== 3'b000) begin
        bad++;
        $display("FAIL rst_idle[%0d] got=%b want=000", k, {led, busy, done});
      end
    end
    capture(3'd1, 3'd1, 1'b0, 40, l, b, d);
    total++;
    if (l !== 64'h0F0F0F0FFF) begin
      bad++;
      $display("FAIL b_led got=%h want=%h", l, 64'h0F0F0F0FFF);
    end
    total++;
    if (b !== 64'h0FFFFFFFFF) begin
      bad++;
      $display("FAIL b_busy got=%h want=%h", b, 64'h0FFFFFFFFF);
    end
    total++;
    if (d !== 64'h1000000000) begin
      bad++;
      $display("FAIL b_done got=%h want=%h", d, 64'h1000000000);
    end
    wait_idle("b");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_letter_e();
`ifndef MORSE_LETTER_GAP_EN
    test_letter_a();
    test_back_to_back();
    test_sel_change();
    test_mid_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Drives a single LED with the Morse pattern of one letter, A through H. The timebase is a free-standing half-second prescaler, a reloading down-counter with enable. On a start request the block latches a letter code, looks up its dot/dash pattern and steps through symbols on prescaler ticks. It sits between the board switches/keys and LEDR[0], and owns the prescaler that sets the Morse unit time.

## Interface
- TICK_CYCLES, default 25000000: clk cycles per Morse unit (half-second at 50 MHz). Legal range 1..2^25. Benches use 4.
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  level-sampled request; accepted only when busy=0.
- letter_sel  input  3  0=A, 1=B … 7=H; sampled only on the accepting edge.
- led  output  1  Morse output; 1=mark, 0=space.
- busy  output  1  high from the cycle after acceptance until the done cycle.
- done  output  1  one-cycle pulse when the sequence completes.

## Operation
- Pattern table (MSB first, dot=0, dash=1), with symbol count:
  - A .- (2), B -... (4), C -.-. (4), D -.. (3)
  - E . (1), F ..-. (4), G --. (3), H .... (4)
- Storage: 4-bit pattern shift register and 3-bit remaining-symbol counter, both loaded on acceptance.
- Prescaler: 25-bit down-counter.
  - Loaded with TICK_CYCLES-1 on acceptance and at every phase boundary.
  - Decrements every cycle while busy; frozen while idle.
  - A tick is the cycle in which the value is 0 and busy=1.
  - The value reloads to TICK_CYCLES-1 on the cycle after a tick; there is no underflow wrap.
- Unit counter: 2 bits; counts ticks within the current phase.
- FSM states:
  - IDLE: led=0, busy=0. start=1 goes to MARK.
  - MARK: led=1. Lasts 1 tick for a dot, 3 ticks for a dash. On the final tick, go to SPACE if symbols remain, otherwise to TAIL (macro) or FIN.
  - SPACE: led=0 for 1 tick. The pattern shifts and the count decrements, then go to MARK.
  - TAIL: led=0 for 3 ticks, then go to FIN. Exists only with MORSE_LETTER_GAP_EN.
  - FIN: done=1, busy=0, led=0 for one cycle, then go to IDLE.
- start while busy=1 is ignored; it is not queued.
- start in the FIN cycle is ignored. The earliest re-accept is the first IDLE cycle.
- letter_sel changes while busy have no effect.
- reset_n low at any time, including mid-MARK:
  - led=0, busy=0, done=0, state IDLE, prescaler reloaded, pattern cleared.
  - Release is synchronous to the next clk edge; no start is accepted on that edge unless start=1.

## Timing
- Reset values: led=0, busy=0, done=0.
- Let E be the accepting edge. busy=1 and led=1 from the cycle after E, so latency is 1 cycle.
- Dot = TICK_CYCLES cycles high. Dash = 3·TICK_CYCLES cycles high. Inter-symbol space = TICK_CYCLES cycles low.
- The FIN cycle immediately follows the last MARK cycle (or the last TAIL cycle).
- Total busy cycles = TICK_CYCLES·(marks + spaces [+3 with macro]).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MORSE_LETTER_GAP_EN defined:
  - The TAIL state is compiled in, adding a 3-unit inter-letter space with led=0 and busy=1 before FIN.
  - Back-to-back letters are then correctly spaced.
- MORSE_LETTER_GAP_EN undefined:
  - No TAIL state; FIN follows the last mark directly.

## Test plan
All scenarios use TICK_CYCLES=4 and the macro undefined unless stated.
- E: start=1, sel=4 for one edge -> led=1 for 4 cycles; done=1 in cycle 5; busy high for exactly 4 cycles.
- A: sel=0 -> led high 4, low 4, high 12; done in cycle 21; busy high for 20 cycles.
- H: sel=7; hold start=1 for the whole run -> led pattern 4/4/4/4/4/4/4 (28 cycles); start ignored during busy and in the FIN cycle; a new sequence begins on the first IDLE edge.
- Reset: sel=1 (B), assert reset_n=0 in cycle 6 of the first dash -> led, busy and done are 0 asynchronously; after release with start=0, the block stays idle and led=0.
- sel change: start with sel=3 (D), then drive sel=7 while busy -> pattern is still D (12 high, 4 low, 4 high, 4 low, 4 high; 28 cycles).
- Macro defined, sel=4 (E) -> led high 4 cycles, low 12 cycles with busy=1; done in cycle 17.
